// File: rtl/c432_event_capture.sv
// Captures c432 grant outputs, glitch-filters them, and queues each newly
// stable grant as a {group, chan} event behind a valid/ready FIFO with statistics.
module c432_event_capture #(
    parameter int DEPTH = 4,
    parameter int FILT  = 2,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pa_in,
    input  logic                     pb_in,
    input  logic                     pc_in,
    input  logic [3:0]               chan_in,
    input  logic                     clr_stat,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [1:0]               evt_group,
    output logic [3:0]               evt_chan,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     ovf,
    output logic                     err,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic [CNT_W-1:0]         err_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int FW = $clog2(FILT + 1);
    localparam logic [FW-1:0]    FILT_CNT  = FW'(FILT);
    localparam logic [LW-1:0]    FULL_LVL  = LW'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    // Code layout is {illegal, group[1:0], chan[3:0]}; IDLE carries no channel.
    localparam logic [6:0]       CODE_IDLE = 7'h00;
    localparam logic [6:0]       CODE_ILL  = 7'h40;

    logic [6:0]       s_q, s_d;
    logic [6:0]       raw_code;
    logic [6:0]       cand_q, cand_d;
    logic [FW-1:0]    cnt_q, cnt_d;
    logic [6:0]       last_code_q, last_code_d;
    logic             push_q, push_d;
    logic [5:0]       push_data_q, push_data_d;
    logic [5:0]       mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             ovf_q, ovf_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             commit;
    logic             pop;
    logic             full;
    logic             do_write;
    logic             drop;
    logic [5:0]       head;

    always_comb begin
        s_d = {pa_in, pb_in, pc_in, chan_in};
    end

    always_comb begin
        case (s_q[6:4])
            3'b000:  raw_code = CODE_IDLE;
            3'b100:  raw_code = {1'b0, 2'd1, s_q[3:0]};
            3'b010:  raw_code = {1'b0, 2'd2, s_q[3:0]};
            3'b001:  raw_code = {1'b0, 2'd3, s_q[3:0]};
            default: raw_code = CODE_ILL;
        endcase
    end

    // Glitch filter; an illegal pattern pins the count at zero so it never commits.
    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        if (raw_code == CODE_ILL) begin
            cand_d = raw_code;
            cnt_d  = '0;
        end else if (raw_code != cand_q) begin
            cand_d = raw_code;
            cnt_d  = FW'(1);
        end else if (cnt_q != FILT_CNT) begin
            cnt_d  = cnt_q + FW'(1);
        end
        commit = (cnt_d == FILT_CNT);
    end

    // Only a change of committed code produces an event, so a held grant yields one.
    always_comb begin
        last_code_d = last_code_q;
        push_d      = 1'b0;
        push_data_d = push_data_q;
        if (commit && (cand_d != last_code_q)) begin
            last_code_d = cand_d;
            push_d      = (cand_d != CODE_IDLE);
            push_data_d = cand_d[5:0];
        end
    end

    always_comb begin
        full     = (level_q == FULL_LVL);
        pop      = evt_valid && evt_ready;
        do_write = push_q && (!full || pop);
        drop     = push_q && full && !pop;
        wr_ptr_d = wr_ptr_q + AW'(do_write);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        level_d  = level_q + LW'(do_write) - LW'(pop);
    end

    // Clear takes priority over any increment in the same cycle.
    always_comb begin
        ovf_d      = ovf_q;
        err_d      = err_q;
        drop_cnt_d = drop_cnt_q;
        err_cnt_d  = err_cnt_q;
        if (clr_stat) begin
            ovf_d      = 1'b0;
            err_d      = 1'b0;
            drop_cnt_d = '0;
            err_cnt_d  = '0;
        end else begin
            if (drop) begin
                ovf_d = 1'b1;
                if (drop_cnt_q != CNT_MAX) begin
                    drop_cnt_d = drop_cnt_q + CNT_W'(1);
                end
            end
            if (raw_code == CODE_ILL) begin
                err_d = 1'b1;
                if (err_cnt_q != CNT_MAX) begin
                    err_cnt_d = err_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q         <= '0;
            cand_q      <= CODE_IDLE;
            cnt_q       <= '0;
            last_code_q <= CODE_IDLE;
            push_q      <= 1'b0;
            push_data_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
            drop_cnt_q  <= '0;
            err_cnt_q   <= '0;
        end else begin
            s_q         <= s_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            last_code_q <= last_code_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            ovf_q       <= ovf_d;
            err_q       <= err_d;
            drop_cnt_q  <= drop_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    // Storage is not reset; stale entries are masked by the occupancy count.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr_q] <= push_data_q;
        end
    end

    always_comb begin
        head       = mem[rd_ptr_q];
        evt_valid  = (level_q != '0);
        evt_group  = evt_valid ? head[5:4] : 2'd0;
        evt_chan   = evt_valid ? head[3:0] : 4'd0;
        fifo_level = level_q;
        ovf        = ovf_q;
        err        = err_q;
        drop_cnt   = drop_cnt_q;
        err_cnt    = err_cnt_q;
    end

endmodule
